// File: rtl/uart_pkg.sv
// Shared UART definitions: TX sequencer states, word-length encoding, data-bit count.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, PARITY, STOP} tx_state_e;

  localparam logic [1:0] WLS_5 = 2'b00;
  localparam logic [1:0] WLS_6 = 2'b01;
  localparam logic [1:0] WLS_7 = 2'b10;
  localparam logic [1:0] WLS_8 = 2'b11;

  function automatic logic [3:0] data_bits(input logic [1:0] wls);
    return {2'b00, wls} + 4'd5;
  endfunction

endpackage

// File: rtl/uart_parity_gen.sv
// Combinational parity over the active data bits; shared by the TX sequencer and RX checker.
module uart_parity_gen
  import uart_pkg::*;
(
  input  logic [7:0] data,
  input  logic [1:0] wls,
  input  logic       eps,
  input  logic       sp,
  output logic       par
);

  logic [7:0] mask;
  logic       odd;

  always_comb begin
    mask = 8'hFF;
    case (wls)
      WLS_5: mask = 8'h1F;
      WLS_6: mask = 8'h3F;
      WLS_7: mask = 8'h7F;
      WLS_8: mask = 8'hFF;
    endcase
    odd = ^(data & mask);
    par = sp ? ~eps : (eps ? odd : ~odd);
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: pops THR/FIFO characters and serialises start/data/parity/stop on txd.
// Define UART_TX_FLOW_CTRL_EN to add cts_n gating of character pops.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic       pclk,
  input  logic       presetn,
  input  logic       baud_tick,
  input  logic       tx_fifo_empty,
  input  logic [7:0] tx_data,
  input  logic [1:0] wls,
  input  logic       stb,
  input  logic       pen,
  input  logic       eps,
  input  logic       sp,
  input  logic       bc,
`ifdef UART_TX_FLOW_CTRL_EN
  input  logic       cts_n,
`endif
  output logic       tsr_load,
  output logic       txd,
  output logic       tx_busy,
  output logic       temt
);

  localparam int TW = $clog2(3 * OVERSAMPLE / 2);
  localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(3 * OVERSAMPLE / 2 - 1);

  tx_state_e     state;
  logic [TW-1:0] tick_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic [1:0]    wls_q;
  logic          stb_q, pen_q, par_q;
  logic          line;
  logic          par, can_pop, bit_end, half_stop, stop_end, start_frame;
  logic [2:0]    data_last;

`ifdef UART_TX_FLOW_CTRL_EN
  assign can_pop = !tx_fifo_empty && !cts_n;
`else
  assign can_pop = !tx_fifo_empty;
`endif

  // Parity is taken from the live inputs and frozen with the rest of the config at pop time.
  uart_parity_gen u_parity (
    .data (tx_data),
    .wls  (wls),
    .eps  (eps),
    .sp   (sp),
    .par  (par)
  );

  assign data_last   = 3'(data_bits(wls_q) - 4'd1);
  assign bit_end     = baud_tick && (tick_cnt == BIT_LAST);
  assign half_stop   = stb_q && (wls_q == WLS_5);
  assign stop_end    = half_stop ? (baud_tick && (tick_cnt == HALF_LAST))
                                 : (bit_end && (!stb_q || bit_cnt[0]));
  assign start_frame = can_pop && ((state == IDLE) || (state == STOP && stop_end));
  assign temt        = (state == IDLE) && tx_fifo_empty;

  // line is the undecorated bit level; txd re-applies break forcing every cycle.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      wls_q    <= '0;
      stb_q    <= 1'b0;
      pen_q    <= 1'b0;
      par_q    <= 1'b0;
      line     <= 1'b1;
      txd      <= 1'b1;
      tsr_load <= 1'b0;
      tx_busy  <= 1'b0;
    end else begin
      tsr_load <= 1'b0;
      txd      <= ~bc & line;
      if (baud_tick && (state inside {START, DATA, PARITY, STOP}))
        tick_cnt <= tick_cnt + 1'b1;
      case (state)
        LOAD: begin
          tx_busy <= 1'b1;
          if (baud_tick && !tsr_load) begin
            state    <= START;
            tick_cnt <= '0;
            line     <= 1'b0;
            txd      <= 1'b0;
          end
        end
        START: if (bit_end) begin
          state    <= DATA;
          tick_cnt <= '0;
          bit_cnt  <= '0;
          line     <= shift[0];
          txd      <= ~bc & shift[0];
        end
        DATA: if (bit_end) begin
          tick_cnt <= '0;
          if (bit_cnt == data_last) begin
            bit_cnt <= '0;
            state   <= pen_q ? PARITY : STOP;
            line    <= pen_q ? par_q : 1'b1;
            txd     <= ~bc & (pen_q ? par_q : 1'b1);
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            shift   <= shift >> 1;
            line    <= shift[1];
            txd     <= ~bc & shift[1];
          end
        end
        PARITY: if (bit_end) begin
          state    <= STOP;
          tick_cnt <= '0;
          bit_cnt  <= '0;
          line     <= 1'b1;
          txd      <= ~bc;
        end
        STOP: begin
          if (stop_end) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            state    <= IDLE;
            tx_busy  <= can_pop;
          end else if (bit_end && !half_stop) begin
            // first of two full stop bits
            tick_cnt <= '0;
            bit_cnt  <= 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
      if (start_frame) begin
        state    <= LOAD;
        tsr_load <= 1'b1;
        shift    <= tx_data;
        wls_q    <= wls;
        stb_q    <= stb;
        pen_q    <= pen;
        par_q    <= par;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: table vectors, random bursts against a frame model,
// plus reset, break and (with UART_TX_FLOW_CTRL_EN) CTS sequences.
module tb_uart_tx_ctrl;
  localparam int OS = 16;

  logic       pclk = 1'b0, presetn = 1'b0, baud_tick = 1'b0, tx_fifo_empty = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic [1:0] wls = 2'b11;
  logic       stb = 1'b0, pen = 1'b0, eps = 1'b0, sp = 1'b0, bc = 1'b0;
  logic       tsr_load, txd, tx_busy, temt;
`ifdef UART_TX_FLOW_CTRL_EN
  logic       cts_n = 1'b0;
`endif

  uart_tx_ctrl #(.OVERSAMPLE(OS)) dut (
    .pclk(pclk), .presetn(presetn), .baud_tick(baud_tick), .tx_fifo_empty(tx_fifo_empty),
    .tx_data(tx_data), .wls(wls), .stb(stb), .pen(pen), .eps(eps), .sp(sp), .bc(bc),
`ifdef UART_TX_FLOW_CTRL_EN
    .cts_n(cts_n),
`endif
    .tsr_load(tsr_load), .txd(txd), .tx_busy(tx_busy), .temt(temt)
  );

  always #5 pclk = ~pclk;

  // one baud tick every 4 clocks, driven just after the rising edge
  int tick_div = 0;
  initial forever begin
    @(posedge pclk); #1;
    tick_div  = (tick_div + 1) % 4;
    baud_tick = (tick_div == 0);
  end

  int         n_cmp = 0, n_bad = 0;
  logic [7:0] fifo_q[$];
  logic [7:0] burst_q[$];
  bit         act[$], expq[$];

  typedef struct {
    logic [7:0] ch;
    logic [1:0] wls;
    logic       stb, pen, eps, sp, exp_par;
    int         exp_gap;
  } vec_t;
  vec_t vecs[9];

  function automatic void check(input string name, input int got, input int want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endfunction

  function automatic void drive_fifo();
    tx_fifo_empty = (fifo_q.size() == 0);
    tx_data       = (fifo_q.size() != 0) ? fifo_q[0] : 8'($urandom);
  endfunction

  // Expected per-tick line levels of one frame, starting with the first start-bit tick.
  function automatic void add_frame(input logic [7:0] ch, input logic [1:0] w, input logic s,
                                    input logic p, input logic e, input logic st);
    int nb = 5 + int'(w);
    int ones = 0;
    int stop_ticks;
    bit pb;
    repeat (OS) expq.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      repeat (OS) expq.push_back(ch[i]);
      ones += int'(ch[i]);
    end
    if (p) begin
      if (st)     pb = !e;
      else if (e) pb = (ones % 2 == 1);
      else        pb = (ones % 2 == 0);
      repeat (OS) expq.push_back(pb);
    end
    stop_ticks = !s ? OS : ((w == 2'b00) ? 3 * OS / 2 : 2 * OS);
    repeat (stop_ticks) expq.push_back(1'b1);
  endfunction

  // Back-to-back frames are separated by the single tick spent waiting in LOAD.
  function automatic void build_burst();
    expq.delete();
    foreach (burst_q[k]) begin
      if (k > 0) expq.push_back(1'b1);
      add_frame(burst_q[k], wls, stb, pen, eps, sp);
      fifo_q.push_back(burst_q[k]);
    end
    drive_fifo();
  endfunction

  task automatic run_check(input string name, input int n_pops, input int budget, input bit scramble);
    int pops = 0, idle_loads = 0, busy_gap = 0, empty_pops = 0, cyc = 0, mism = 0;
    bit done = 0, scrambled = 0;
    act.delete();
    while (!done && cyc < budget) begin
      @(negedge pclk); cyc++;
      if (baud_tick) act.push_back(txd);
      if (tsr_load) begin
        if (fifo_q.size() == 0) empty_pops++;
        else void'(fifo_q.pop_front());
        if (!tx_busy) idle_loads++;
        pops++;
        drive_fifo();
      end else if (!tx_busy && !temt && pops > 0) busy_gap++;
      if (scramble && !scrambled && pops == n_pops && !tsr_load) begin
        wls = 2'($urandom_range(0, 3)); stb = 1'($urandom); pen = 1'($urandom);
        eps = 1'($urandom); sp = 1'($urandom);
        scrambled = 1;
      end
      done = (pops == n_pops) && temt;
    end
    check({name, " completes"}, int'(done), 1);
    check({name, " pops"}, pops, n_pops);
    check({name, " pops from idle"}, idle_loads, 1);
    check({name, " busy gaps"}, busy_gap, 0);
    check({name, " pops while empty"}, empty_pops, 0);
    while (act.size() != 0 && act[0] == 1'b1) void'(act.pop_front());
    for (int i = 0; i < expq.size(); i++)
      if (i >= act.size() || act[i] !== expq[i]) mism++;
    for (int i = expq.size(); i < act.size(); i++)
      if (act[i] !== 1'b1) mism++;
    check({name, " txd ticks wrong"}, mism, 0);
  endtask

  initial begin
    int nb, idx, p, g, cyc, ticks, bad, pops;
    vecs[0] = '{8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 17};
    vecs[1] = '{8'hA3, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 17};
    vecs[2] = '{8'hA3, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 17};
    vecs[3] = '{8'hA3, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 17};
    vecs[4] = '{8'h1F, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 25};
    vecs[5] = '{8'h55, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 33};
    vecs[6] = '{8'h6C, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 17};
    vecs[7] = '{8'hE6, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 17};
    vecs[8] = '{8'h1F, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 25};

    // reset state, temt tracking the FIFO flag while held in reset
    #12;
    check("reset txd", int'(txd), 1);
    check("reset tsr_load", int'(tsr_load), 0);
    check("reset tx_busy", int'(tx_busy), 0);
    check("reset temt", int'(temt), 1);
    tx_fifo_empty = 1'b0; #1;
    check("reset temt follows fifo", int'(temt), 0);
    tx_fifo_empty = 1'b1;
    @(negedge pclk); presetn = 1'b1;
    repeat (3) @(negedge pclk);

    for (int v = 0; v < 9; v++) begin
      wls = vecs[v].wls; stb = vecs[v].stb; pen = vecs[v].pen; eps = vecs[v].eps; sp = vecs[v].sp;
      burst_q.delete();
      burst_q.push_back(vecs[v].ch); burst_q.push_back(vecs[v].ch);
      build_burst();
      run_check($sformatf("vec%0d", v), 2, 2000, 1'b0);
      nb = 5 + int'(vecs[v].wls);
      if (vecs[v].pen) begin
        idx = OS * (1 + nb) + OS / 2;
        check($sformatf("vec%0d parity bit", v), (idx < act.size()) ? int'(act[idx]) : -1,
              int'(vecs[v].exp_par));
      end
      p = OS * (1 + nb + int'(vecs[v].pen));
      g = -1;
      for (int i = p; i < act.size(); i++)
        if (act[i] == 1'b0) begin g = i - p; break; end
      check($sformatf("vec%0d stop+load ticks", v), g, vecs[v].exp_gap);
    end

    for (int r = 0; r < 6; r++) begin
      wls = 2'($urandom_range(0, 3)); stb = 1'($urandom); pen = 1'($urandom);
      eps = 1'($urandom); sp = 1'($urandom);
      burst_q.delete();
      repeat ($urandom_range(1, 3)) burst_q.push_back(8'($urandom));
      build_burst();
      run_check($sformatf("rand%0d", r), burst_q.size(), 900 * burst_q.size() + 300, burst_q.size() == 1);
    end

    // asynchronous reset in the middle of data bit 3
    wls = 2'b11; stb = 1'b0; pen = 1'b0; eps = 1'b0; sp = 1'b0;
    fifo_q.push_back(8'h96); fifo_q.push_back(8'h3C); drive_fifo();
    cyc = 0; ticks = -1;
    while (cyc < 2000 && ticks < OS * 4 + OS / 2) begin
      @(negedge pclk); cyc++;
      if (tsr_load) begin void'(fifo_q.pop_front()); drive_fifo(); end
      if (baud_tick) begin
        if (ticks >= 0) ticks++;
        else if (txd == 1'b0) ticks = 1;
      end
    end
    check("reset test reached data bit 3", int'(ticks >= OS * 4 + OS / 2), 1);
    #1 presetn = 1'b0;
    #1;
    check("async reset txd", int'(txd), 1);
    check("async reset tx_busy", int'(tx_busy), 0);
    check("async reset temt with char pending", int'(temt), 0);
    @(negedge pclk);
    check("in reset no tsr_load", int'(tsr_load), 0);
    presetn = 1'b1;
    expq.delete();
    add_frame(8'h3C, wls, stb, pen, eps, sp);
    run_check("restart after reset", 1, 1200, 1'b0);

    // break mid-frame: line held low, both characters still consumed
    wls = 2'b11; pen = 1'b1; eps = 1'b1; sp = 1'b0; stb = 1'b0;
    fifo_q.push_back(8'hFF); fifo_q.push_back(8'h81); drive_fifo();
    cyc = 0; ticks = -1;
    while (cyc < 2000 && ticks < OS * 3) begin
      @(negedge pclk); cyc++;
      if (tsr_load) begin void'(fifo_q.pop_front()); drive_fifo(); end
      if (baud_tick) begin
        if (ticks >= 0) ticks++;
        else if (txd == 1'b0) ticks = 1;
      end
    end
    bc = 1'b1;
    cyc = 0; bad = 0; pops = 0;
    while (cyc < 3000 && !(fifo_q.size() == 0 && temt)) begin
      @(negedge pclk); cyc++;
      if (tsr_load) begin pops++; void'(fifo_q.pop_front()); drive_fifo(); end
      if (txd !== 1'b0) bad++;
    end
    check("break frames complete", int'(fifo_q.size() == 0 && temt), 1);
    check("break second char popped", pops, 1);
    check("break cycles with txd high", bad, 0);
    bc = 1'b0;
    @(negedge pclk);
    check("break release txd", int'(txd), 1);

`ifdef UART_TX_FLOW_CTRL_EN
    wls = 2'b11; pen = 1'b0; stb = 1'b0;
    fifo_q.push_back(8'h5A); drive_fifo();
    cyc = 0;
    while (cyc < 200 && !tsr_load) begin @(negedge pclk); cyc++; end
    check("cts first pop", int'(tsr_load), 1);
    void'(fifo_q.pop_front());
    cts_n = 1'b1;
    fifo_q.push_back(8'hC3); drive_fifo();
    @(negedge pclk);
    cyc = 0; pops = 0;
    while (cyc < 1500 && tx_busy) begin @(negedge pclk); cyc++; if (tsr_load) pops++; end
    check("cts in-flight frame finishes", int'(tx_busy), 0);
    repeat (200) begin @(negedge pclk); if (tsr_load) pops++; end
    check("cts blocked pops", pops, 0);
    check("cts temt with char held", int'(temt), 0);
    cts_n = 1'b0;
    expq.delete();
    add_frame(8'hC3, wls, stb, pen, eps, sp);
    run_check("cts release", 1, 1200, 1'b0);
`endif

    check("final temt", int'(temt), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
